// File: rtl/codeword_byte_packer.sv
// codeword_byte_packer
//
// Buffers 24-bit encoded words from the turbo encoder in a small FIFO. Each word is then
// split into three bytes for the UART byte transmitter. Both sides use a valid/ready
// handshake.
//
// Build option: define CODEWORD_PACKER_SYNC_EN to prefix every frame with SYNC_BYTE.
// A frame is then four bytes: SYNC_BYTE, b0, b1, b2. Without the macro a frame is b0, b1, b2.
//
// Parameters
//   DEPTH      FIFO depth in words (power of 2, >= 2)
//   MSB_FIRST  1: bits [23:16] go first; 0: bits [7:0] go first
//   SYNC_BYTE  frame marker (only present with CODEWORD_PACKER_SYNC_EN)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_valid    encoder word strobe
//   in_word     encoded word
//   in_ready    FIFO not full
//   byte_data   byte to UART transmitter (registered)
//   byte_valid  byte_data is valid (registered)
//   byte_ready  UART transmitter accepts a byte
//   fifo_count  number of words stored (the word being sent is not counted)
//   overflow    sticky: a word arrived while the FIFO was full
//   busy        FSM not idle
module codeword_byte_packer #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
`ifdef CODEWORD_PACKER_SYNC_EN
    ,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [23:0]            in_word,
    output logic                   in_ready,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

`ifdef CODEWORD_PACKER_SYNC_EN
    typedef enum logic [1:0] {StIdle, StSync, StSend} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

    state_e state_q, state_d;

    // FIFO storage
    logic [23:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    // Byte serialiser
    logic [23:0]     shreg_q, shreg_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;

    logic            push;
    logic            pop;
    logic            xfer;
    logic [23:0]     head_word;

    // Byte i of a word in transmit order.
    function automatic logic [7:0] pick(input logic [23:0] w, input logic [1:0] i);
        logic [7:0] b;
        if (MSB_FIRST) begin
            case (i)
                2'd0:    b = w[23:16];
                2'd1:    b = w[15:8];
                default: b = w[7:0];
            endcase
        end else begin
            case (i)
                2'd0:    b = w[7:0];
                2'd1:    b = w[15:8];
                default: b = w[23:16];
            endcase
        end
        return b;
    endfunction

    assign in_ready  = (count_q != CntW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign xfer      = byte_valid_q && byte_ready;
    assign head_word = mem_q[rd_ptr_q];

    // ---------------------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // ---------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
`ifdef CODEWORD_PACKER_SYNC_EN
                    state_d = StSync;
`else
                    state_d = StSend;
`endif
                end
            end
`ifdef CODEWORD_PACKER_SYNC_EN
            StSync: begin
                if (xfer) begin
                    state_d = StSend;
                end
            end
`endif
            StSend: begin
                if (xfer && (idx_q == 2'd2)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs. The byte register is loaded one cycle after entering a sending state.
    // Back-to-back bytes of one frame follow without a gap while byte_ready stays high.
    always_comb begin
        byte_valid_d = byte_valid_q;
        byte_data_d  = byte_data_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        case (state_q)
            StIdle: begin
                byte_valid_d = 1'b0;
                if (pop) begin
                    shreg_d = head_word;
                    idx_d   = 2'd0;
                end
            end
`ifdef CODEWORD_PACKER_SYNC_EN
            StSync: begin
                if (!byte_valid_q) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = SYNC_BYTE;
                end else if (xfer) begin
                    byte_data_d = pick(shreg_q, 2'd0);
                end
            end
`endif
            StSend: begin
                if (!byte_valid_q) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = pick(shreg_q, idx_q);
                end else if (xfer) begin
                    if (idx_q == 2'd2) begin
                        byte_valid_d = 1'b0;
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        byte_data_d = pick(shreg_q, idx_q + 2'd1);
                    end
                end
            end
            default: byte_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            idx_q        <= 2'd0;
            shreg_q      <= 24'h0;
        end else begin
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_codeword_byte_packer.sv
// Bench for codeword_byte_packer. Two instances (MSB first / LSB first) share one stimulus.
// A queue-based model tracks stored words and the frame currently being sent.
// Build option CODEWORD_PACKER_SYNC_EN adds the sync byte to the expected frames.
module tb_codeword_byte_packer;

    localparam int unsigned DEPTH = 4;
`ifdef CODEWORD_PACKER_SYNC_EN
    localparam int Off = 1;
`else
    localparam int Off = 0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_word;
    logic        byte_ready;

    logic        in_ready_m, byte_valid_m, overflow_m, busy_m;
    logic [7:0]  byte_data_m;
    logic [2:0]  fifo_count_m;
    logic        in_ready_l, byte_valid_l, overflow_l, busy_l;
    logic [7:0]  byte_data_l;
    logic [2:0]  fifo_count_l;

    codeword_byte_packer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready_m),
        .byte_data  (byte_data_m),
        .byte_valid (byte_valid_m),
        .byte_ready (byte_ready),
        .fifo_count (fifo_count_m),
        .overflow   (overflow_m),
        .busy       (busy_m)
    );

    codeword_byte_packer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready_l),
        .byte_data  (byte_data_l),
        .byte_valid (byte_valid_l),
        .byte_ready (byte_ready),
        .fifo_count (fifo_count_l),
        .overflow   (overflow_l),
        .busy       (busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    logic [23:0] m_q[$];
    logic [7:0]  m_fm[$];
    logic [7:0]  m_fl[$];
    bit          m_busy;
    bit          m_setup;
    bit          m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q     = {};
        m_fm    = {};
        m_fl    = {};
        m_busy  = 1'b0;
        m_setup = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of the model, using the inputs the DUT sampled at that edge.
    task automatic model_step();
        int          pre;
        logic [23:0] w;
        if (!reset) return;
        pre = m_q.size();
        if (m_busy) begin
            if (m_setup) begin
                m_setup = 1'b0;
            end else if (byte_ready) begin
                void'(m_fm.pop_front());
                void'(m_fl.pop_front());
                if (m_fm.size() == 0) m_busy = 1'b0;
            end
        end else if (pre != 0) begin
            w    = m_q.pop_front();
            m_fm = {};
            m_fl = {};
`ifdef CODEWORD_PACKER_SYNC_EN
            m_fm.push_back(8'hA5);
            m_fl.push_back(8'hA5);
`endif
            m_fm.push_back(w[23:16]);
            m_fm.push_back(w[15:8]);
            m_fm.push_back(w[7:0]);
            m_fl.push_back(w[7:0]);
            m_fl.push_back(w[15:8]);
            m_fl.push_back(w[23:16]);
            m_busy  = 1'b1;
            m_setup = 1'b1;
        end
        if (in_valid) begin
            if (pre == int'(DEPTH)) m_ovf = 1'b1;
            else m_q.push_back(in_word);
        end
    endtask

    // Drive inputs for one cycle; returns 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [23:0] w, input logic r);
        in_valid   = v;
        in_word    = w;
        byte_ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset(input string tag);
        in_valid = 1'b0;
        reset    = 1'b0;
        model_clear();
        #1;
        check({tag, "_byte_valid"}, byte_valid_m, 0);
        check({tag, "_byte_data"},  byte_data_m,  0);
        check({tag, "_busy"},       busy_m,       0);
        check({tag, "_fifo_count"}, fifo_count_m, 0);
        check({tag, "_in_ready"},   in_ready_m,   1);
        check({tag, "_overflow"},   overflow_m,   0);
        cycle(1'b0, 24'h0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0);
        reset = 1'b1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",       in_ready_m,   (m_q.size() != int'(DEPTH)));
            check("fifo_count",     fifo_count_m, 32'(m_q.size()));
            check("overflow",       overflow_m,   m_ovf);
            check("busy",           busy_m,       m_busy);
            check("byte_valid",     byte_valid_m, (m_busy && !m_setup));
            check("lsb_fifo_count", fifo_count_l, 32'(m_q.size()));
            check("lsb_overflow",   overflow_l,   m_ovf);
            check("lsb_busy",       busy_l,       m_busy);
            check("lsb_byte_valid", byte_valid_l, (m_busy && !m_setup));
            check("lsb_in_ready",   in_ready_l,   (m_q.size() != int'(DEPTH)));
            if (m_busy && !m_setup) begin
                check("byte_data",     byte_data_m, m_fm[0]);
                check("lsb_byte_data", byte_data_l, m_fl[0]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_m[$];
        logic [7:0] exp_l[$];
        logic [7:0] got[$];
        logic [7:0] exp4[$];
        int         nv;

        in_valid   = 1'b0;
        in_word    = 24'h0;
        byte_ready = 1'b0;
        reset      = 1'b1;
        model_clear();
        #2;
        chk_en = 1'b1;
        apply_reset("rst0");

        // T1 / T2: latency and byte order for both instances
        exp_m = {};
        exp_l = {};
`ifdef CODEWORD_PACKER_SYNC_EN
        exp_m.push_back(8'hA5);
        exp_l.push_back(8'hA5);
`endif
        exp_m.push_back(8'h12); exp_m.push_back(8'h34); exp_m.push_back(8'h56);
        exp_l.push_back(8'hEF); exp_l.push_back(8'hCD); exp_l.push_back(8'hAB);
        cycle(1'b1, 24'h123456, 1'b1);
        cycle(1'b1, 24'hABCDEF, 1'b1);
        check("t1_valid_after_pop", byte_valid_m, 0);
        check("t1_busy_after_pop",  busy_m,       1);
        check("t1_model_first",     m_fm[Off],    8'h12);
        for (int k = 0; k < exp_m.size(); k++) begin
            cycle(1'b0, 24'h0, 1'b1);
            check("t1_valid",   byte_valid_m, 1);
            check("t1_byte",    byte_data_m,  exp_m[k]);
            check("t1_busy",    busy_m,       1);
        end
        cycle(1'b0, 24'h0, 1'b1);
        check("t1_valid_drop", byte_valid_m, 0);
        check("t1_busy_drop",  busy_m,       0);
        // second word (ABCDEF) on the LSB-first instance
        cycle(1'b0, 24'h0, 1'b1);
        check("t2_model_first", m_fl[Off], 8'hEF);
        for (int k = 0; k < exp_l.size(); k++) begin
            cycle(1'b0, 24'h0, 1'b1);
            check("t2_lsb_valid", byte_valid_l, 1);
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 24'h0, 1'b1);

        // T3: stall on byte 1
        apply_reset("rst3");
        cycle(1'b1, 24'h123456, 1'b1);
        cycle(1'b0, 24'h0, 1'b1);
        for (int k = 0; k < 2 + Off; k++) cycle(1'b0, 24'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 24'h0, 1'b0);
            check("t3_hold_valid", byte_valid_m, 1);
            check("t3_hold_data",  byte_data_m,  8'h34);
        end
        cycle(1'b0, 24'h0, 1'b1);
        check("t3_resume", byte_data_m, 8'h56);
        cycle(1'b0, 24'h0, 1'b1);
        check("t3_end", byte_valid_m, 0);

        // T4: fill with the UART stalled; one word sits in the shift register
        apply_reset("rst4");
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 24'(k), 1'b0);
            if (k == 2) check("t4_count_after2", fifo_count_m, 1);
            if (k == 5) begin
                check("t4_count_full", fifo_count_m, 4);
                check("t4_in_ready",   in_ready_m,   0);
                check("t4_no_ovf_yet", overflow_m,   0);
            end
        end
        check("t4_overflow", overflow_m,   1);
        check("t4_count",    fifo_count_m, 4);
        exp4 = {};
        for (int k = 1; k <= 5; k++) begin
`ifdef CODEWORD_PACKER_SYNC_EN
            exp4.push_back(8'hA5);
`endif
            exp4.push_back(8'h00);
            exp4.push_back(8'h00);
            exp4.push_back(8'(k));
        end
        got = {};
        for (int c = 0; c < 200 && got.size() < exp4.size(); c++) begin
            if (byte_valid_m) got.push_back(byte_data_m);
            cycle(1'b0, 24'h0, 1'b1);
        end
        check("t4_drain_len", got.size(), exp4.size());
        for (int k = 0; k < got.size() && k < exp4.size(); k++) begin
            check("t4_order", got[k], exp4[k]);
        end
        check("t4_ovf_sticky", overflow_m, 1);

        // T5: asynchronous reset while byte 2 is on the bus with two words queued
        apply_reset("rst5a");
        cycle(1'b1, 24'hC0FFEE, 1'b0);
        cycle(1'b1, 24'h111111, 1'b0);
        cycle(1'b1, 24'h222222, 1'b0);
        for (int k = 0; k < 2 + Off; k++) cycle(1'b0, 24'h0, 1'b1);
        check("t5_pre_count", fifo_count_m, 2);
        check("t5_pre_byte",  byte_data_m,  8'hEE);
        #2;
        apply_reset("t5_async");
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 24'h0, 1'b1);
            if (byte_valid_m) nv++;
        end
        check("t5_no_bytes", nv, 0);

        // Randomised traffic with occasional mid-cycle resets
        for (int k = 0; k < 2500; k++) begin
            cycle(($urandom_range(0, 99) < 55), 24'($urandom()),
                  ($urandom_range(0, 99) < 65));
            if ($urandom_range(0, 799) == 0) begin
                #2;
                apply_reset("rnd_rst");
            end
        end
        for (int k = 0; k < 40; k++) cycle(1'b0, 24'h0, 1'b1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
